// File: rtl/sprite_mover.sv
// rtl/sprite_mover.sv - frame-rate keyboard sprite mover with per-axis ramp and exact edge clamp
module sprite_mover #(
    parameter int         X_CENTER     = 480,
    parameter int         Y_CENTER     = 240,
    parameter int         X_MIN        = 0,
    parameter int         X_MAX        = 639,
    parameter int         Y_MIN        = 0,
    parameter int         Y_MAX        = 479,
    parameter int         SIZE         = 4,
    parameter int         MAX_SPEED    = 4,
    parameter int         ACCEL_FRAMES = 8,
    parameter int         NUM_KEYS     = 2,
    parameter logic [7:0] KEY_LEFT     = 8'd80,
    parameter logic [7:0] KEY_RIGHT    = 8'd79,
    parameter logic [7:0] KEY_DOWN     = 8'd81,
    parameter logic [7:0] KEY_UP       = 8'd82
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    input  logic [8*NUM_KEYS-1:0] keycodes,
    input  logic                  freeze,
    output logic [9:0]            PosX,
    output logic [9:0]            PosY,
    output logic [9:0]            Size,
    output logic [3:0]            SpeedX,
    output logic [3:0]            SpeedY,
    output logic [1:0]            Facing,
    output logic [3:0]            AtEdge
);

    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_NEG  = 2'd1;
    localparam logic [1:0] DIR_POS  = 2'd2;

    localparam int              HW        = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [HW-1:0]   HOLD_LAST = HW'(ACCEL_FRAMES - 1);
    localparam logic [3:0]      SPEED_TOP = 4'(MAX_SPEED);

    localparam logic signed [11:0] X_LO = 12'(X_MIN + SIZE);
    localparam logic signed [11:0] X_HI = 12'(X_MAX - SIZE);
    localparam logic signed [11:0] Y_LO = 12'(Y_MIN + SIZE);
    localparam logic signed [11:0] Y_HI = 12'(Y_MAX - SIZE);

    logic          key_l, key_r, key_u, key_d;
    logic [1:0]    dir_x_new, dir_y_new;
    logic [1:0]    dir_x_q, dir_y_q;
    logic [HW-1:0] hold_x, hold_y;
    logic [HW+4:0] step_x, step_y;
    logic [1:0]    facing_next;

    // Returns {start, speed_next, hold_next} for one axis.
    function automatic logic [HW+4:0] axis_step(
        input logic [1:0]    dn,
        input logic [1:0]    dq,
        input logic [3:0]    spd,
        input logic [HW-1:0] hc
    );
        logic          start;
        logic [3:0]    s;
        logic [HW-1:0] h;
        start = 1'b0;
        s     = spd;
        h     = hc;
        if (dn == DIR_NONE) begin
            s = 4'd0;
            h = '0;
        end else if (dn != dq) begin
            start = 1'b1;
            s     = 4'd1;
            h     = '0;
        end else if (hc == HOLD_LAST) begin
            if (spd < SPEED_TOP) begin
                s = spd + 4'd1;
                h = '0;
            end
        end else begin
            h = hc + 1'b1;
        end
        return {start, s, h};
    endfunction

    // Signed 12-bit arithmetic so a move past zero clamps instead of wrapping.
    function automatic logic [9:0] move_clamp(
        input logic [9:0]          pos,
        input logic [1:0]          dn,
        input logic [3:0]          spd,
        input logic signed [11:0]  lo,
        input logic signed [11:0]  hi
    );
        logic signed [11:0] p;
        p = $signed({2'b00, pos});
        if (dn == DIR_NEG)
            p = p - $signed({8'd0, spd});
        else if (dn == DIR_POS)
            p = p + $signed({8'd0, spd});
        if (p < lo)
            p = lo;
        else if (p > hi)
            p = hi;
        return p[9:0];
    endfunction

    always_comb begin
        key_l = 1'b0;
        key_r = 1'b0;
        key_u = 1'b0;
        key_d = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keycodes[8*i +: 8] == KEY_LEFT)  key_l = 1'b1;
            if (keycodes[8*i +: 8] == KEY_RIGHT) key_r = 1'b1;
            if (keycodes[8*i +: 8] == KEY_UP)    key_u = 1'b1;
            if (keycodes[8*i +: 8] == KEY_DOWN)  key_d = 1'b1;
        end
    end

    assign dir_x_new = (key_l ^ key_r) ? (key_l ? DIR_NEG : DIR_POS) : DIR_NONE;
    assign dir_y_new = (key_u ^ key_d) ? (key_u ? DIR_NEG : DIR_POS) : DIR_NONE;

    assign step_x = axis_step(dir_x_new, dir_x_q, SpeedX, hold_x);
    assign step_y = axis_step(dir_y_new, dir_y_q, SpeedY, hold_y);

    always_comb begin
        facing_next = Facing;
        if (step_x[HW+4])
            facing_next = (dir_x_new == DIR_NEG) ? 2'd1 : 2'd0;
        else if (step_y[HW+4])
            facing_next = (dir_y_new == DIR_NEG) ? 2'd3 : 2'd2;
    end

    // Freeze forgets the held direction so a key held across it restarts at speed 1.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            PosX    <= 10'(X_CENTER);
            PosY    <= 10'(Y_CENTER);
            SpeedX  <= 4'd0;
            SpeedY  <= 4'd0;
            hold_x  <= '0;
            hold_y  <= '0;
            dir_x_q <= DIR_NONE;
            dir_y_q <= DIR_NONE;
            Facing  <= 2'd0;
        end else if (freeze) begin
            SpeedX  <= 4'd0;
            SpeedY  <= 4'd0;
            hold_x  <= '0;
            hold_y  <= '0;
            dir_x_q <= DIR_NONE;
            dir_y_q <= DIR_NONE;
        end else begin
            SpeedX  <= step_x[HW+3:HW];
            SpeedY  <= step_y[HW+3:HW];
            hold_x  <= step_x[HW-1:0];
            hold_y  <= step_y[HW-1:0];
            dir_x_q <= dir_x_new;
            dir_y_q <= dir_y_new;
            PosX    <= move_clamp(PosX, dir_x_new, step_x[HW+3:HW], X_LO, X_HI);
            PosY    <= move_clamp(PosY, dir_y_new, step_y[HW+3:HW], Y_LO, Y_HI);
            Facing  <= facing_next;
        end
    end

    assign Size = 10'(SIZE);

    assign AtEdge[0] = (PosX == X_LO[9:0]);
    assign AtEdge[1] = (PosX == X_HI[9:0]);
    assign AtEdge[2] = (PosY == Y_LO[9:0]);
    assign AtEdge[3] = (PosY == Y_HI[9:0]);

endmodule

// File: tb/tb_sprite_mover.sv
// tb/tb_sprite_mover.sv - table-driven bench for sprite_mover with default parameters
module tb_sprite_mover;

    logic        frame_clk;
    logic        Reset;
    logic [15:0] keycodes;
    logic        freeze;
    logic [9:0]  PosX, PosY, Size;
    logic [3:0]  SpeedX, SpeedY;
    logic [1:0]  Facing;
    logic [3:0]  AtEdge;

    int tests;
    int failed;

    sprite_mover dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycodes  (keycodes),
        .freeze    (freeze),
        .PosX      (PosX),
        .PosY      (PosY),
        .Size      (Size),
        .SpeedX    (SpeedX),
        .SpeedY    (SpeedY),
        .Facing    (Facing),
        .AtEdge    (AtEdge)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic        rst;
        logic [15:0] keys;
        logic        frz;
        int          reps;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [3:0]  sx;
        logic [3:0]  sy;
        logic [1:0]  face;
        logic [3:0]  at;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic [15:0] keys, input logic frz, input int reps,
                       input logic [9:0] x, input logic [9:0] y, input logic [3:0] sx,
                       input logic [3:0] sy, input logic [1:0] face, input logic [3:0] at);
        vec_t v;
        v.rst = rst; v.keys = keys; v.frz = frz; v.reps = reps;
        v.x = x; v.y = y; v.sx = sx; v.sy = sy; v.face = face; v.at = at;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [9:0] x, input logic [9:0] y,
                           input logic [3:0] sx, input logic [3:0] sy,
                           input logic [1:0] face, input logic [3:0] at);
        chk({tag, " PosX"},   16'(PosX),   16'(x));
        chk({tag, " PosY"},   16'(PosY),   16'(y));
        chk({tag, " SpeedX"}, 16'(SpeedX), 16'(sx));
        chk({tag, " SpeedY"}, 16'(SpeedY), 16'(sy));
        chk({tag, " Facing"}, 16'(Facing), 16'(face));
        chk({tag, " AtEdge"}, 16'(AtEdge), 16'(at));
    endtask

    initial begin
        tests    = 0;
        failed   = 0;
        Reset    = 1'b1;
        keycodes = 16'd0;
        freeze   = 1'b0;

        // rst, {slot1,slot0}, freeze, frames, PosX, PosY, SpeedX, SpeedY, Facing, AtEdge
        add(0, {8'd0,  8'd0 }, 0,  5, 480, 240, 0, 0, 0, 4'b0000);
        add(0, {8'd0,  8'd80}, 0,  1, 479, 240, 1, 0, 1, 4'b0000);
        add(0, {8'd0,  8'd80}, 0,  1, 478, 240, 1, 0, 1, 4'b0000);
        add(0, {8'd0,  8'd80}, 0,  1, 477, 240, 1, 0, 1, 4'b0000);
        add(0, {8'd0,  8'd0 }, 0,  1, 477, 240, 0, 0, 1, 4'b0000);
        add(0, {8'd0,  8'd0 }, 0,  1, 477, 240, 0, 0, 1, 4'b0000);
        add(1, {8'd0,  8'd79}, 0,  8, 488, 240, 1, 0, 0, 4'b0000);
        add(0, {8'd0,  8'd79}, 0,  1, 490, 240, 2, 0, 0, 4'b0000);
        add(0, {8'd0,  8'd79}, 0,  7, 504, 240, 2, 0, 0, 4'b0000);
        add(0, {8'd0,  8'd79}, 0,  1, 507, 240, 3, 0, 0, 4'b0000);
        add(1, {8'd0,  8'd79}, 0,  1, 481, 240, 1, 0, 0, 4'b0000);
        add(0, {8'd0,  8'd0 }, 0,  1, 481, 240, 0, 0, 0, 4'b0000);
        add(0, {8'd0,  8'd79}, 0, 50, 633, 240, 4, 0, 0, 4'b0000);
        add(0, {8'd0,  8'd79}, 0,  1, 635, 240, 4, 0, 0, 4'b0010);
        add(0, {8'd0,  8'd79}, 0,  3, 635, 240, 4, 0, 0, 4'b0010);
        add(1, {8'd0,  8'd82}, 0, 80, 480,   4, 0, 4, 3, 4'b0100);
        add(0, {8'd0,  8'd81}, 0,  1, 480,   5, 0, 1, 2, 4'b0000);
        add(0, {8'd0,  8'd0 }, 0,  1, 480,   5, 0, 0, 2, 4'b0000);
        add(0, {8'd0,  8'd82}, 0,  1, 480,   4, 0, 1, 3, 4'b0100);
        add(1, {8'd82, 8'd79}, 0,  1, 481, 239, 1, 1, 0, 4'b0000);
        add(1, {8'd80, 8'd79}, 0,  1, 480, 240, 0, 0, 0, 4'b0000);
        add(0, {8'd0,  8'd82}, 0,  1, 480, 239, 0, 1, 3, 4'b0000);
        add(0, {8'd80, 8'd80}, 0,  1, 479, 239, 1, 0, 1, 4'b0000);
        add(0, {8'd80, 8'd80}, 1,  1, 479, 239, 0, 0, 1, 4'b0000);
        add(0, {8'd80, 8'd80}, 0,  1, 478, 239, 1, 0, 1, 4'b0000);

        @(negedge frame_clk);
        Reset = 1'b0;
        chk("Size", 16'(Size), 16'd4);

        foreach (vq[i]) begin
            @(negedge frame_clk);
            if (vq[i].rst) begin
                Reset = 1'b1;
                #1 Reset = 1'b0;
            end
            keycodes = vq[i].keys;
            freeze   = vq[i].frz;
            repeat (vq[i].reps) @(posedge frame_clk);
            #1;
            chk_all($sformatf("row%0d", i), vq[i].x, vq[i].y, vq[i].sx, vq[i].sy,
                    vq[i].face, vq[i].at);
        end

        // Asynchronous reset mid-ramp, then restart with right still held
        @(negedge frame_clk);
        freeze = 1'b0;
        Reset = 1'b1;
        #1 Reset = 1'b0;
        keycodes = {8'd0, 8'd79};
        repeat (18) @(posedge frame_clk);
        #1;
        chk_all("ramp18", 510, 240, 3, 0, 0, 4'b0000);
        @(negedge frame_clk);
        #1 Reset = 1'b1;
        #1;
        chk_all("async_rst", 480, 240, 0, 0, 0, 4'b0000);
        Reset = 1'b0;
        @(posedge frame_clk);
        #1;
        chk_all("post_rst", 481, 240, 1, 0, 0, 4'b0000);

        // Freeze during a hold, then the ramp restarts at speed 1
        repeat (8) @(posedge frame_clk);
        #1;
        chk_all("pre_frz", 490, 240, 2, 0, 0, 4'b0000);
        @(negedge frame_clk);
        freeze = 1'b1;
        repeat (3) @(posedge frame_clk);
        #1;
        chk_all("frozen", 490, 240, 0, 0, 0, 4'b0000);
        @(negedge frame_clk);
        freeze = 1'b0;
        @(posedge frame_clk);
        #1;
        chk_all("unfrz", 491, 240, 1, 0, 0, 4'b0000);
        repeat (8) @(posedge frame_clk);
        #1;
        chk_all("reramp", 500, 240, 2, 0, 0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
